// File: rtl/trivium_pkg.sv
// trivium_pkg: state encoding and sizing constants shared by trivium_ctrl and its helpers.
package trivium_pkg;

  typedef enum logic [2:0] {
    ST_KEY,
    ST_IV,
    ST_LOAD,
    ST_WARM,
    ST_READY,
    ST_GEN,
    ST_WRITE,
    ST_PREF
  } state_t;

  localparam int KEY_W         = 80;
  localparam int IV_W          = 80;
  localparam int WARMUP_CYCLES = 1152;
  localparam int WARM_CNT_W    = 11;
  localparam int KS_BITS       = 8;

endpackage

// File: rtl/trivium_byte_hold.sv
// trivium_byte_hold: one-byte parking slot for received bytes the sequencer cannot take yet.
module trivium_byte_hold (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_store,
  input  logic       i_take,
  input  logic [7:0] i_data,
  output logic       o_full,
  output logic [7:0] o_data
);

  logic       r_full;
  logic [7:0] r_data;

  // A store is accepted when the slot is empty or is being emptied in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_store && (!r_full || i_take)) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_take) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/trivium_ctrl.sv
// trivium_ctrl: collects key/IV from UART bytes, warms up the Trivium core, then encrypts bytes into the TX FIFO.
// Define TRIVIUM_KS_PREFETCH_EN to pre-generate each keystream byte ahead of the next plaintext byte.
module trivium_ctrl #(
  parameter int KEY_BYTES     = trivium_pkg::KEY_W / 8,
  parameter int IV_BYTES      = trivium_pkg::IV_W / 8,
  parameter int WARMUP_CYCLES = trivium_pkg::WARMUP_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [7:0]             fifo_wr_data,
  output logic [8*KEY_BYTES-1:0] triv_key,
  output logic [8*IV_BYTES-1:0]  triv_iv,
  output logic                   triv_load,
  output logic                   triv_step,
  input  logic                   triv_ks,
  output logic                   ready,
  output logic                   overrun
);

  import trivium_pkg::*;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [7:0]             r_byteCnt;
  logic [WARM_CNT_W-1:0]  r_cnt;
  logic [KS_BITS-1:0]     r_ks;
  logic [KS_BITS-1:0]     w_ksNext;
  logic [8*KEY_BYTES-1:0] r_key;
  logic [8*IV_BYTES-1:0]  r_iv;
  logic [7:0]             r_wrData;
  logic                   r_overrun;
`ifdef TRIVIUM_KS_PREFETCH_EN
  logic                   r_ksValid;
`else
  logic [7:0]             r_pt;
`endif

  logic       w_holdFull;
  logic [7:0] w_holdData;
  logic       w_readyOk;
  logic       w_take;
  logic       w_holdTake;
  logic       w_holdStore;
  logic       w_drop;
  logic       w_inKeyIv;
  logic       w_byteLast;
  logic       w_cntLast;
  logic [7:0] w_inByte;

`ifdef TRIVIUM_KS_PREFETCH_EN
  assign w_readyOk = (r_state == ST_READY) && r_ksValid;
`else
  assign w_readyOk = (r_state == ST_READY);
`endif

  // The hold slot is always served before a fresh byte so arrival order is preserved.
  assign w_inKeyIv   = (r_state == ST_KEY) || (r_state == ST_IV);
  assign w_take      = w_readyOk && (w_holdFull || rx_valid);
  assign w_holdTake  = w_readyOk && w_holdFull;
  assign w_holdStore = rx_valid && !w_inKeyIv && !(w_readyOk && !w_holdFull);
  assign w_drop      = w_holdStore && w_holdFull && !w_holdTake;
  assign w_inByte    = w_holdFull ? w_holdData : rx_data;

  assign w_byteLast = (r_state == ST_KEY) ? (r_byteCnt == 8'(KEY_BYTES - 1))
                                          : (r_byteCnt == 8'(IV_BYTES - 1));
  assign w_cntLast  = (r_state == ST_WARM) ? (r_cnt == WARM_CNT_W'(WARMUP_CYCLES - 1))
                                           : (r_cnt == WARM_CNT_W'(KS_BITS - 1));
  assign w_ksNext   = {triv_ks, r_ks[KS_BITS-1:1]};

  trivium_byte_hold u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_store (w_holdStore),
    .i_take  (w_holdTake),
    .i_data  (rx_data),
    .o_full  (w_holdFull),
    .o_data  (w_holdData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_KEY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    triv_load   = 1'b0;
    triv_step   = 1'b0;
    ready       = 1'b0;
    fifo_wr_en  = 1'b0;
    unique case (r_state)
      ST_KEY: begin
        if (rx_valid && w_byteLast) w_stateNext = ST_IV;
      end
      ST_IV: begin
        if (rx_valid && w_byteLast) w_stateNext = ST_LOAD;
      end
      ST_LOAD: begin
        triv_load   = 1'b1;
        w_stateNext = ST_WARM;
      end
      ST_WARM: begin
        triv_step = 1'b1;
`ifdef TRIVIUM_KS_PREFETCH_EN
        if (w_cntLast) w_stateNext = ST_PREF;
`else
        if (w_cntLast) w_stateNext = ST_READY;
`endif
      end
      ST_READY: begin
        ready = 1'b1;
`ifdef TRIVIUM_KS_PREFETCH_EN
        if (w_take) w_stateNext = ST_WRITE;
`else
        if (w_take) w_stateNext = ST_GEN;
`endif
      end
      ST_GEN: begin
        triv_step = 1'b1;
        if (w_cntLast) w_stateNext = ST_WRITE;
      end
      ST_WRITE: begin
        if (!fifo_full) begin
          fifo_wr_en = 1'b1;
`ifdef TRIVIUM_KS_PREFETCH_EN
          w_stateNext = ST_PREF;
`else
          w_stateNext = ST_READY;
`endif
        end
      end
      ST_PREF: begin
`ifdef TRIVIUM_KS_PREFETCH_EN
        triv_step = 1'b1;
        if (w_cntLast) w_stateNext = ST_READY;
`else
        w_stateNext = ST_KEY;
`endif
      end
    endcase
  end

  // Key and IV shift in from the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byteCnt <= '0;
      r_cnt     <= '0;
      r_ks      <= '0;
      r_key     <= '0;
      r_iv      <= '0;
      r_wrData  <= '0;
      r_overrun <= 1'b0;
`ifdef TRIVIUM_KS_PREFETCH_EN
      r_ksValid <= 1'b0;
`else
      r_pt      <= '0;
`endif
    end else begin
      if (rx_valid && w_inKeyIv) begin
        r_byteCnt <= w_byteLast ? '0 : r_byteCnt + 1'b1;
      end
      if (rx_valid && (r_state == ST_KEY)) begin
        r_key <= {rx_data, r_key[8*KEY_BYTES-1:8]};
      end
      if (rx_valid && (r_state == ST_IV)) begin
        r_iv <= {rx_data, r_iv[8*IV_BYTES-1:8]};
      end
      if (triv_step) begin
        r_cnt <= w_cntLast ? '0 : r_cnt + 1'b1;
        r_ks  <= w_ksNext;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
`ifdef TRIVIUM_KS_PREFETCH_EN
      if ((r_state == ST_PREF) && w_cntLast) begin
        r_ksValid <= 1'b1;
      end else if (w_take) begin
        r_ksValid <= 1'b0;
      end
      if (w_take) begin
        r_wrData <= w_inByte ^ r_ks;
      end
`else
      if (w_take) begin
        r_pt <= w_inByte;
      end
      if ((r_state == ST_GEN) && w_cntLast) begin
        r_wrData <= r_pt ^ w_ksNext;
      end
`endif
    end
  end

  assign triv_key     = r_key;
  assign triv_iv      = r_iv;
  assign fifo_wr_data = r_wrData;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_trivium_ctrl.sv
// tb_trivium_ctrl: directed stimulus plus a per-cycle behavioural model of trivium_ctrl with a keystream core stub.
module tb_trivium_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic [79:0] triv_key;
  logic [79:0] triv_iv;
  logic        triv_load;
  logic        triv_step;
  logic        triv_ks;
  logic        ready;
  logic        overrun;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  trivium_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .triv_key     (triv_key),
    .triv_iv      (triv_iv),
    .triv_load    (triv_load),
    .triv_step    (triv_step),
    .triv_ks      (triv_ks),
    .ready        (ready),
    .overrun      (overrun)
  );

  // Keystream bit number n after load; the first post-warm-up byte is 1,0,1,0,0,0,0,0.
  function automatic logic ksBit(input int n);
    int         v;
    logic [7:0] firstByte;
    firstByte = 8'b0000_0101;
    if (n < 1152) begin
      v = n ^ (n >> 4);
      return v[0];
    end else if (n < 1160) begin
      return firstByte[n - 1152];
    end
    v = n ^ (n >> 2) ^ (n >> 5);
    return v[0];
  endfunction

  function automatic logic [7:0] ksByte(input int j);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = ksBit(1152 + 8 * j + i);
    return b;
  endfunction

  // Core stub: counts steps since the last load and presents the matching keystream bit.
  int stepIdx;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         stepIdx <= 0;
    else if (triv_load) stepIdx <= 0;
    else if (triv_step) stepIdx <= stepIdx + 1;
  end
  assign triv_ks = ksBit(stepIdx);

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendKeyIv(input logic [7:0] keyBase, input logic [7:0] ivBase);
    for (int i = 0; i < 10; i++) applyStimulus(keyBase + 8'(i));
    for (int i = 0; i < 10; i++) applyStimulus(ivBase + 8'(i));
  endtask

  task automatic countWarm(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (triv_step) n++;
      else break;
    end
  endtask

  task automatic waitWrEn(output int lat);
    lat = 1;
    while (!fifo_wr_en && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!fifo_wr_en) checkOutput("wr_en_timeout", fifo_wr_en, 1);
  endtask

  // Behavioural model: byte accounting, load/warm-up timing and ciphertext scoreboard.
  int          mSeen;
  logic [79:0] mKey;
  logic [79:0] mIv;
  logic        mLoadDue;
  logic        mLoaded;
  int          mSteps;
  logic        mReadyChecked;
  logic [7:0]  mQ[$];
  int          mEnc;
  logic        mOverrun;
  int          cap;
  logic [7:0]  expCt;

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_ctrl_outputs", {triv_load, triv_step, ready, overrun, fifo_wr_en}, '0);
      checkOutput("rst_wr_data", fifo_wr_data, '0);
      checkOutput("rst_key_iv", {16'h0, triv_key ^ triv_iv} | {16'h0, triv_key}, '0);
      mSeen = 0; mKey = '0; mIv = '0; mLoadDue = 1'b0; mLoaded = 1'b0;
      mSteps = 0; mReadyChecked = 1'b0; mQ.delete(); mEnc = 0; mOverrun = 1'b0;
    end else begin
      checkOutput("load_timing", triv_load, mLoadDue);
      checkOutput("load_step_excl", triv_load & triv_step, 0);
      checkOutput("overrun_model", overrun, mOverrun);
      if (triv_load) begin
        checkOutput("load_key", triv_key, mKey);
        checkOutput("load_iv", triv_iv, mIv);
      end
      if (!mLoaded) begin
        checkOutput("pre_warm_idle", {triv_step, ready, fifo_wr_en}, 0);
      end else if (mSteps < 1152) begin
        checkOutput("warm_step", {triv_step, ready, fifo_wr_en}, 3'b100);
      end else if (!mReadyChecked) begin
        checkOutput("first_ready", {triv_step, ready, fifo_wr_en}, 3'b010);
        mReadyChecked = 1'b1;
      end
      if (ready) checkOutput("ready_quiet", {triv_step, fifo_wr_en}, 0);

      if (rx_valid) begin
        if (mSeen < 10) begin
          mKey |= 80'(rx_data) << (8 * mSeen);
        end else if (mSeen < 20) begin
          mIv |= 80'(rx_data) << (8 * (mSeen - 10));
        end else begin
          cap = (mLoaded && mSteps >= 1152) ? 2 : 1;
          if (mQ.size() >= cap) mOverrun = 1'b1;
          else mQ.push_back(rx_data);
        end
        if (mSeen < 20) begin
          mSeen++;
          if (mSeen == 20) mLoadDue = 1'b1;
        end
      end

      if (fifo_wr_en) begin
        checkOutput("wr_while_full", fifo_full, 0);
        if (mQ.size() == 0) begin
          checkOutput("wr_unexpected", fifo_wr_en, 0);
        end else begin
          expCt = mQ.pop_front() ^ ksByte(mEnc);
          mEnc++;
          checkOutput("ciphertext_model", fifo_wr_data, expCt);
        end
      end

      if (triv_load) begin
        mLoaded  = 1'b1;
        mLoadDue = 1'b0;
        mSteps   = 0;
      end else if (mLoaded && triv_step) begin
        mSteps++;
      end
    end
  end

  initial begin
    int lat;
    int n;
    int extra;
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk); #1;
    checkOutput("reset_state", {triv_load, triv_step, ready, overrun, fifo_wr_en}, '0);
    rst_n = 1'b1;

    sendKeyIv(8'h01, 8'hF0);
    checkOutput("load_pulse", triv_load, 1);
    checkOutput("key_packing", triv_key, 80'h0A09_0807_0605_0403_0201);
    checkOutput("iv_packing", triv_iv, 80'hF9F8_F7F6_F5F4_F3F2_F1F0);

    countWarm(n);
    checkOutput("warm_step_count", n, 1152);
    checkOutput("ready_after_warm", {ready, fifo_wr_en}, 2'b10);

    applyStimulus(8'h41);
    waitWrEn(lat);
    checkOutput("byte_latency", lat, 9);
    checkOutput("ct_41", fifo_wr_data, 8'h44);

    @(posedge clk); #1;
    checkOutput("ready_after_write", ready, 1);
    applyStimulus(8'h55);
    fifo_full = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_no_wr", fifo_wr_en, 0);
      checkOutput("stall_no_step", triv_step, 0);
      checkOutput("stall_data", fifo_wr_data, 8'h0F);
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;
    #1;
    checkOutput("stall_release_wr", fifo_wr_en, 1);
    checkOutput("stall_release_data", fifo_wr_data, 8'h0F);
    @(posedge clk); #1;
    checkOutput("single_wr", fifo_wr_en, 0);

    applyStimulus(8'h10);
    applyStimulus(8'h20);
    applyStimulus(8'h30);
    waitWrEn(lat);
    checkOutput("ct_10", fifo_wr_data, 8'h10 ^ ksByte(2));
    @(posedge clk); #1;
    waitWrEn(lat);
    checkOutput("ct_20", fifo_wr_data, 8'h20 ^ ksByte(3));
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (fifo_wr_en) extra++;
    end
    checkOutput("byte_30_dropped", extra, 0);
    checkOutput("overrun_sticky", overrun, 1);

    rst_n = 1'b0;
    #1;
    checkOutput("overrun_cleared", overrun, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sendKeyIv(8'h20, 8'h60);
    checkOutput("load_pulse_2", triv_load, 1);
    repeat (500) @(posedge clk);
    #1;
    checkOutput("mid_warm_step", triv_step, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ctrl", {triv_load, triv_step, ready, overrun, fifo_wr_en}, '0);
    checkOutput("async_rst_key", triv_key, '0);
    checkOutput("async_rst_iv", triv_iv, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    sendKeyIv(8'h01, 8'hF0);
    checkOutput("load_pulse_3", triv_load, 1);
    countWarm(n);
    checkOutput("warm_step_count_3", n, 1152);
    checkOutput("ready_after_warm_3", ready, 1);
    applyStimulus(8'hA5);
    waitWrEn(lat);
    checkOutput("byte_latency_3", lat, 9);
    checkOutput("ct_A5", fifo_wr_data, 8'hA0);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
